// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus sequencer
// and the access-time delay stage that partners with it.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDR_SETUP = 3'd1,
        ST_ADDR_LATCH = 3'd2,
        ST_DATA_START = 3'd3,
        ST_WAIT_ACC   = 3'd4,
        ST_WAIT_END   = 3'd5,
        ST_RECOVER    = 3'd6,
        ST_DONE       = 3'd7
    } rtc_state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int DEF_ADDR_CYC    = 2;
    localparam int DEF_HOLD_CYC    = 1;
    localparam int DEF_REC_CYC     = 2;
    localparam int DEF_TIMEOUT_CYC = 32;
    localparam int DEF_TW          = 6;

    // Phase counter width; phase lengths are small configuration constants.
    localparam int PHASE_W = 8;

endpackage

// File: rtl/rtc_phase_counter.sv
// Loadable down-counter with a zero flag. Holds at zero once it gets there,
// so a stalled phase can never wrap back to a large count.
module rtc_phase_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Runs one read or write cycle on the multiplexed RTC bus and uses the
// delayed access window from the delay stage to time capture and strobe end.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | bus released, waiting for start_i
// ADDR_SETUP  | cs low, ALE high, address driven (ADDR_CYC cycles)
// ADDR_LATCH  | ALE low, address held (HOLD_CYC cycles)
// DATA_START  | strobe asserted, one-cycle request to the delay stage
// WAIT_ACC    | strobe held, waiting for the access window to open
// WAIT_END    | strobe held, waiting for the access window to close
// RECOVER     | all strobes and cs released (REC_CYC cycles)
// DONE        | one-cycle completion pulse
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int ADDR_CYC    = DEF_ADDR_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int REC_CYC     = DEF_REC_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TW          = DEF_TW
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] ad_in_i,
    output logic [7:0] ad_out_o,
    output logic       ad_oe_o,
    output logic       cs_n_o,
    output logic       ale_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output logic       tacc_en_o,
    output logic       tacc_req_n_o,
    input  logic       tacc_win_n_i,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    rtc_state_e state_q, state_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic [7:0] ad_out_q, ad_out_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ad_oe_q, ad_oe_d;
    logic       cs_n_q, cs_n_d;
    logic       ale_q, ale_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       tacc_en_q, tacc_en_d;
    logic       tacc_req_n_q, tacc_req_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic               ph_load;
    logic [PHASE_W-1:0] ph_load_val;
    logic               ph_zero;
    logic               to_load;
    logic               to_en;
    logic               to_zero;

    rtc_phase_counter #(.W(PHASE_W)) u_phase_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (ph_load),
        .load_val_i (ph_load_val),
        .en_i       (1'b1),
        .zero_o     (ph_zero)
    );

    rtc_phase_counter #(.W(TW)) u_timeout_cnt (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load_i     (to_load),
        .load_val_i (TW'(TIMEOUT_CYC - 1)),
        .en_i       (to_en),
        .zero_o     (to_zero)
    );

    // Next state and captured request fields.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ADDR_SETUP;
                    rw_d    = rw_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    error_d = 1'b0;
                end
            end
            ST_ADDR_SETUP: if (ph_zero) state_d = ST_ADDR_LATCH;
            ST_ADDR_LATCH: if (ph_zero) state_d = ST_DATA_START;
            ST_DATA_START: state_d = ST_WAIT_ACC;
            ST_WAIT_ACC: begin
                if (!tacc_win_n_i) begin
                    state_d = ST_WAIT_END;
                    if (rw_q == RW_READ) rdata_d = ad_in_i;
                end else if (to_zero) begin
                    state_d = ST_RECOVER;
                    error_d = 1'b1;
                end
            end
            ST_WAIT_END: begin
                if (tacc_win_n_i) begin
                    state_d = ST_RECOVER;
                end else if (to_zero) begin
                    state_d = ST_RECOVER;
                    error_d = 1'b1;
                end
            end
            ST_RECOVER: if (ph_zero) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every output is a flop.
    always_comb begin
        cs_n_d       = 1'b1;
        ale_d        = 1'b0;
        ad_oe_d      = 1'b0;
        ad_out_d     = ad_out_q;
        rd_n_d       = 1'b1;
        wr_n_d       = 1'b1;
        tacc_en_d    = 1'b0;
        tacc_req_n_d = 1'b1;
        done_d       = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        case (state_d)
            ST_ADDR_SETUP: begin
                cs_n_d   = 1'b0;
                ale_d    = 1'b1;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            ST_ADDR_LATCH: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            ST_DATA_START, ST_WAIT_ACC, ST_WAIT_END: begin
                cs_n_d    = 1'b0;
                tacc_en_d = 1'b1;
                if (state_d == ST_DATA_START) tacc_req_n_d = 1'b0;
                if (rw_d == RW_READ) begin
                    rd_n_d = 1'b0;
                end else begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ph_load     = (state_d != state_q);
        ph_load_val = '0;
        case (state_d)
            ST_ADDR_SETUP: ph_load_val = PHASE_W'(ADDR_CYC - 1);
            ST_ADDR_LATCH: ph_load_val = PHASE_W'(HOLD_CYC - 1);
            ST_RECOVER:    ph_load_val = PHASE_W'(REC_CYC - 1);
            default:       ph_load_val = '0;
        endcase
    end

    assign to_load = (state_d != state_q) &&
                     ((state_d == ST_WAIT_ACC) || (state_d == ST_WAIT_END));
    assign to_en   = (state_q == ST_WAIT_ACC) || (state_q == ST_WAIT_END);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            rw_q         <= RW_WRITE;
            addr_q       <= '0;
            wdata_q      <= '0;
            ad_out_q     <= '0;
            rdata_q      <= '0;
            ad_oe_q      <= 1'b0;
            cs_n_q       <= 1'b1;
            ale_q        <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            tacc_en_q    <= 1'b0;
            tacc_req_n_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ad_out_q     <= ad_out_d;
            rdata_q      <= rdata_d;
            ad_oe_q      <= ad_oe_d;
            cs_n_q       <= cs_n_d;
            ale_q        <= ale_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            tacc_en_q    <= tacc_en_d;
            tacc_req_n_q <= tacc_req_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign ad_out_o     = ad_out_q;
    assign ad_oe_o      = ad_oe_q;
    assign cs_n_o       = cs_n_q;
    assign ale_o        = ale_q;
    assign rd_n_o       = rd_n_q;
    assign wr_n_o       = wr_n_q;
    assign tacc_en_o    = tacc_en_q;
    assign tacc_req_n_o = tacc_req_n_q;
    assign rdata_o      = rdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: directed and random transactions against a
// cycle-timeline reference model plus a behavioural access-delay stage.
module tb_rtc_bus_sequencer;

    localparam int A_CYC = 2;
    localparam int H_CYC = 1;
    localparam int R_CYC = 2;
    localparam int T_CYC = 32;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       start_i;
    logic       rw_i;
    logic [7:0] addr_i;
    logic [7:0] wdata_i;
    logic [7:0] ad_in_i;
    logic [7:0] ad_out_o;
    logic       ad_oe_o;
    logic       cs_n_o;
    logic       ale_o;
    logic       rd_n_o;
    logic       wr_n_o;
    logic       tacc_en_o;
    logic       tacc_req_n_o;
    logic       tacc_win_n_i;
    logic [7:0] rdata_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    always #5 clk_i = ~clk_i;

    rtc_bus_sequencer dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .start_i      (start_i),
        .rw_i         (rw_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .ad_in_i      (ad_in_i),
        .ad_out_o     (ad_out_o),
        .ad_oe_o      (ad_oe_o),
        .cs_n_o       (cs_n_o),
        .ale_o        (ale_o),
        .rd_n_o       (rd_n_o),
        .wr_n_o       (wr_n_o),
        .tacc_en_o    (tacc_en_o),
        .tacc_req_n_o (tacc_req_n_o),
        .tacc_win_n_i (tacc_win_n_i),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Current transaction timeline (absolute cycle numbers).
    bit         have_txn = 1'b0;
    int         s_c, t_r, t_we, t_rec, t_done;
    bit         t_rw, t_to;
    logic [7:0] t_addr, t_wdata, t_base;
    logic [7:0] m_rdata_prev = 8'h00;
    bit         m_err_prev   = 1'b0;
    int         done_seen;

    // Delay-stage model state.
    bit dly_en = 1'b0;
    bit armed  = 1'b0;
    int dly_d  = 4;
    int dly_l  = 7;
    int arm_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the negedge.
    task automatic step();
        bit win_low;
        if (dly_en && tacc_req_n_o === 1'b0) begin
            armed   = 1'b1;
            arm_cyc = cyc;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        win_low = armed && (cyc >= arm_cyc + 1 + dly_d) && (cyc <= arm_cyc + dly_d + dly_l);
        tacc_win_n_i = !win_low;
        ad_in_i = win_low ? 8'(t_base + 8'(cyc - (arm_cyc + 1 + dly_d))) : 8'($urandom);
    endtask

    task automatic check_cycle();
        int         c;
        bit         act, sel, ale, stb, req, oe, dn, er;
        logic [9:0] ctl_e, ctl_o;
        logic [7:0] rd_e;
        c   = cyc;
        act = have_txn && (c >= s_c + 1) && (c <= t_done);
        sel = act && (c < t_rec);
        ale = act && (c <= s_c + A_CYC);
        stb = act && (c >= t_r) && (c < t_rec);
        req = act && (c == t_r);
        oe  = act && ((c < t_r) || (stb && !t_rw));
        dn  = act && (c == t_done);
        er  = (have_txn && c >= s_c + 1) ? (t_to && c >= t_rec) : m_err_prev;
        rd_e = (have_txn && t_rw && !t_to && c >= t_we) ? t_base : m_rdata_prev;
        ctl_e = {!sel, ale, !(stb && t_rw), !(stb && !t_rw), oe, stb, !req, act, dn, er};
        ctl_o = {cs_n_o, ale_o, rd_n_o, wr_n_o, ad_oe_o, tacc_en_o, tacc_req_n_o,
                 busy_o, done_o, error_o};
        chk($sformatf("ctl@%0d", c), 32'(ctl_o), 32'(ctl_e));
        if (oe) chk($sformatf("ad_out@%0d", c), 32'(ad_out_o), 32'((c < t_r) ? t_addr : t_wdata));
        chk($sformatf("rdata@%0d", c), 32'(rdata_o), 32'(rd_e));
    endtask

    // noise: 0 start low, 1 random start, 2 start held high, 3 start pulsed in WAIT_END
    task automatic run_txn(input bit rw, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] base, input int d, input int l, input bit en,
                           input int gap, input int noise, input int rst_at);
        bit hit_rst;
        hit_rst = 1'b0;
        for (int i = 0; i < gap; i++) begin
            start_i = 1'b0;
            check_cycle();
            step();
        end
        if (have_txn) begin
            if (t_rw && !t_to) m_rdata_prev = t_base;
            m_err_prev = t_to;
        end
        have_txn = 1'b1;
        s_c = cyc; t_rw = rw; t_addr = a; t_wdata = wd; t_base = base; t_to = !en;
        t_r = s_c + A_CYC + H_CYC + 1;
        if (!t_to) begin
            t_we  = t_r + d + 2;
            t_rec = t_r + d + l + 2;
        end else begin
            t_we  = 32'h7fff_ffff;
            t_rec = t_r + 1 + T_CYC;
        end
        t_done = t_rec + R_CYC;
        dly_en = en; dly_d = d; dly_l = l;
        done_seen = -1;
        start_i = 1'b1; rw_i = rw; addr_i = a; wdata_i = wd;
        check_cycle();
        step();
        while (cyc <= t_done) begin
            case (noise)
                0:       start_i = 1'b0;
                1:       start_i = 1'($urandom);
                2:       start_i = 1'b1;
                default: start_i = (cyc >= t_we) && (cyc < t_rec);
            endcase
            rw_i = 1'($urandom); addr_i = 8'($urandom); wdata_i = 8'($urandom);
            if (rst_at != 0 && cyc == s_c + rst_at) reset_n_i = 1'b0;
            check_cycle();
            if (done_o === 1'b1) done_seen = cyc;
            step();
            if (reset_n_i == 1'b0) begin
                reset_n_i = 1'b1; start_i = 1'b0;
                have_txn = 1'b0; m_rdata_prev = 8'h00; m_err_prev = 1'b0;
                check_cycle();
                chk("rst_ad_out", 32'(ad_out_o), 32'h0);
                step();
                hit_rst = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        if (!hit_rst) chk("done_at", 32'(done_seen), 32'(t_done));
    endtask

    initial begin
        reset_n_i = 1'b0; start_i = 1'b0; rw_i = 1'b0; addr_i = 8'h00; wdata_i = 8'h00;
        ad_in_i = 8'h00; tacc_win_n_i = 1'b1; t_base = 8'h00;
        step();
        step();
        check_cycle();
        chk("rst_ad_out", 32'(ad_out_o), 32'h0);
        reset_n_i = 1'b1;
        step();

        // Default read: addr 0x21, bus returns 0x5A.
        run_txn(1'b1, 8'h21, 8'h00, 8'h5A, 4, 7, 1'b1, 2, 0, 0);
        chk("rd_done_rel", 32'(done_seen - s_c), 32'd19);
        chk("rd_rdata", 32'(rdata_o), 32'h5A);

        // Write: addr 0x02, data 0x37.
        run_txn(1'b0, 8'h02, 8'h37, 8'hC3, 4, 7, 1'b1, 1, 0, 0);
        chk("wr_done_rel", 32'(done_seen - s_c), 32'd19);
        chk("wr_rdata_kept", 32'(rdata_o), 32'h5A);

        // Window never asserted: timeout after 32 cycles in WAIT_ACC.
        run_txn(1'b1, 8'h44, 8'h00, 8'h99, 4, 7, 1'b0, 1, 0, 0);
        chk("to_done_rel", 32'(done_seen - s_c), 32'd39);
        chk("to_error", 32'(error_o), 32'h1);
        chk("to_rdata_kept", 32'(rdata_o), 32'h5A);

        // start_i held high: back-to-back transactions.
        run_txn(1'b1, 8'h10, 8'h00, 8'h11, 4, 7, 1'b1, 0, 2, 0);
        run_txn(1'b0, 8'h12, 8'hA5, 8'h22, 4, 7, 1'b1, 0, 2, 0);
        run_txn(1'b1, 8'h14, 8'h00, 8'h33, 4, 7, 1'b1, 0, 2, 0);

        // start_i pulsed during WAIT_END is ignored.
        run_txn(1'b1, 8'h30, 8'h00, 8'h6C, 4, 7, 1'b1, 1, 3, 0);

        // Reset in cycle 11 of a read.
        run_txn(1'b1, 8'h21, 8'h00, 8'h77, 4, 7, 1'b1, 1, 0, 11);
        for (int i = 0; i < 10; i++) begin
            check_cycle();
            step();
        end

        for (int n = 0; n < 25; n++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 6)), int'($urandom_range(1, 10)),
                    ($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 0);
        end
        for (int i = 0; i < 3; i++) begin
            check_cycle();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Upstream bus-cycle sequencer for the multiplexed address/data RTC interface.
- Runs one complete read or write transaction on the RTC pins: chip select, address latch, then RD or WR strobe.
- In the data phase it sends a single-cycle active-low request pulse to the access-time delay stage. That stage returns a delayed active-low access window, which this block consumes to time the data capture and the end of the strobe.

Parameters:
- ADDR_CYC, 2: cycles the address is driven with ALE high (minimum 1).
- HOLD_CYC, 1: cycles the address is held after ALE falls (minimum 1).
- REC_CYC, 2: recovery cycles with all strobes inactive before done (minimum 1).
- TIMEOUT_CYC, 32: maximum cycles spent in each wait state before aborting.
- TW, 6: width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- clk_i, in, 1: system clock.
- reset_n_i, in, 1: synchronous, active-low reset.
- start_i, in, 1: request a transaction; sampled only in IDLE.
- rw_i, in, 1: 1 = read, 0 = write; captured with start_i.
- addr_i, in, 8: register address; captured with start_i.
- wdata_i, in, 8: write data; captured with start_i.
- ad_in_i, in, 8: AD bus input from the pad.
- ad_out_o, out, 8: AD bus output value.
- ad_oe_o, out, 1: AD bus output enable.
- cs_n_o, out, 1: RTC chip select, active low.
- ale_o, out, 1: address latch enable.
- rd_n_o, out, 1: read strobe, active low.
- wr_n_o, out, 1: write strobe, active low.
- tacc_en_o, out, 1: enable to the delay stage.
- tacc_req_n_o, out, 1: request pulse to the delay stage, active low.
- tacc_win_n_i, in, 1: delayed access window from the delay stage, active low.
- rdata_o, out, 8: captured read data.
- busy_o, out, 1: high in every state except IDLE.
- done_o, out, 1: one-cycle pulse at the end of a transaction.
- error_o, out, 1: sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Reset values: cs_n/rd_n/wr_n/tacc_req_n = 1; ale, ad_oe, tacc_en, busy, done, error = 0; ad_out and rdata = 0; state = IDLE.
- Reset asserted mid-transaction returns the block to these values on the next edge. No completion pulse is produced.
- All outputs are registered.
- States:
  - IDLE: on start_i, capture rw/addr/wdata, clear error, go to ADDR_SETUP.
  - ADDR_SETUP, ADDR_CYC cycles: cs_n=0, ale=1, ad_oe=1, ad_out=addr.
  - ADDR_LATCH, HOLD_CYC cycles: ale=0, address still driven.
  - DATA_START, 1 cycle:
    - Read: rd_n=0, ad_oe=0.
    - Write: wr_n=0, ad_out=wdata, ad_oe=1.
    - tacc_en=1; tacc_req_n=0 for this cycle only. The delay stage re-arms while the request is low, so it must never be low for two cycles.
  - WAIT_ACC: strobe held, tacc_en=1. On the first cycle tacc_win_n_i is sampled 0: on a read, rdata_o <= ad_in_i in that same edge; go to WAIT_END.
  - WAIT_END: strobe held. When tacc_win_n_i is sampled 1, go to RECOVER.
  - RECOVER, REC_CYC cycles: rd_n=wr_n=1, cs_n=1, ad_oe=0, tacc_en=0.
  - DONE, 1 cycle: done_o=1, then IDLE.
- Timeout:
  - One shared counter, cleared on entry to WAIT_ACC and again on entry to WAIT_END.
  - Reaching TIMEOUT_CYC sets error_o=1 and goes to RECOVER; done_o still pulses.
  - rdata_o is left unchanged on a timed-out read.
- start_i in any state other than IDLE is ignored; there is no queuing.
- Counter rules:
  - Phase counters count 0..N-1 and clear on every state change.
  - No wrap-around is possible within legal parameters.
- Timing of the delay stage as a bench model:
  - It arms on the edge where it samples the request low.
  - The window goes low 4 edges later and stays low for 7 cycles.

Decomposition:
- Shared package rtc_bus_pkg holds:
  - the state encoding constants;
  - the read/write codes;
  - default parameter values, shared with the delay stage and the top-level controller.
- One natural sub-module, rtc_phase_counter: a loadable down-counter with a zero flag, reused for the ADDR/HOLD/REC phases and the timeout.

Test Plan:
- Read with defaults: start at cycle 0, addr=0x21, bus model returns 0x5A.
  - Required: ale high in cycles 1-2, tacc_req_n low only in cycle 4, window low in cycles 9-15, rdata_o=0x5A after cycle 9.
  - Required: cs_n high from cycle 17, done_o high in cycle 19.
- Write, addr=0x02, wdata=0x37:
  - Required: ad_out=0x37 and ad_oe=1 whenever wr_n=0; rd_n stays 1; done_o in cycle 19; error_o=0.
- Window never asserted (delay model disabled):
  - Required: error_o=1 after 32 cycles in WAIT_ACC, strobes released, done_o pulses, rdata_o unchanged.
- start_i held high continuously:
  - Required: back-to-back transactions, with cs_n high for at least REC_CYC cycles between them and exactly one tacc_req_n low cycle per transaction.
- Assert reset_n_i=0 in cycle 11 of a read:
  - Required: next cycle all strobes inactive, busy=0, done_o never pulses.
- start_i pulsed during WAIT_END:
  - Required: ignored; only one done_o; block returns to IDLE.
